addr_mode_seq: RTL

Parametrised effective-address sequencer for the 6502-style core, the next generation of the addressing-mode logic inside `cpu`. Given an addressing mode, index registers and the operand address, it walks the operand, pointer and page-fix memory cycles and returns the effective address (EA). Compared with the current sequencer it adds:
- full group-01 mode coverage, including (zp,X);
- a memory req/ack handshake that allows wait states;
- parametrised data width;
- selectable zero-page wrap;
- forced fix-up cycles for store-type ops.

It sits between instruction decode and the memory port.

---
 rtl/addr_mode_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/addr_mode_seq.sv
// Effective-address sequencer for the 6502-style core: walks operand, pointer and
// page-fix reads over a req/ack memory port and returns the effective address.
module addr_mode_seq #(
    parameter int DATA_W     = 8,
    parameter bit ZP_WRAP    = 1'b1,
    parameter bit FIX_ALWAYS = 1'b0,
    localparam int AW        = 2 * DATA_W
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              START,
    input  logic [2:0]        MODE,
    input  logic              WR_OP,
    input  logic [DATA_W-1:0] IDX_X,
    input  logic [DATA_W-1:0] IDX_Y,
    input  logic [AW-1:0]     PC_IN,
    output logic              MEM_REQ,
    output logic [AW-1:0]     MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [AW-1:0]     EA,
    output logic [1:0]        OPLEN,
    output logic              EXTRA
);

    typedef enum logic [2:0] {S_IDLE, S_OPL, S_OPH, S_PTRL, S_PTRH, S_FIX, S_DONE} state_t;
    typedef enum logic [2:0] {
        M_IZX = 3'd0, M_ZP  = 3'd1, M_IMM = 3'd2, M_ABS = 3'd3,
        M_IZY = 3'd4, M_ZPX = 3'd5, M_ABY = 3'd6, M_ABX = 3'd7
    } mode_t;

    state_t            state, state_n;
    mode_t             mode_q;
    logic              wr_q;
    logic [DATA_W-1:0] x_q, y_q, b_q, h_q, pl_q, ph_q;
    logic [AW-1:0]     pc_q, ea_q, ea_next;
    logic [1:0]        oplen_q;
    logic              extra_q;

    logic              access, ack_ok, start_ok;
    logic [DATA_W-1:0] b_v, h_v, ph_v, idx, base_lo, base_hi_q, base_hi_v, hi_inc;
    logic [DATA_W:0]   lo_sum;
    logic              carry, fix_need, is_abs;

    // Zero-page address of a+i+inc, either wrapped inside page zero or carrying into bit DATA_W.
    function automatic logic [AW-1:0] zp_addr(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] i,
                                              input logic              inc);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, i} + {{DATA_W{1'b0}}, inc};
        if (ZP_WRAP) return {{DATA_W{1'b0}}, s[DATA_W-1:0]};
        else         return {{(DATA_W-1){1'b0}}, s};
    endfunction

    assign access   = (state == S_OPL) || (state == S_OPH) || (state == S_PTRL) ||
                      (state == S_PTRH) || (state == S_FIX);
    assign ack_ok   = access && MEM_ACK;
    assign start_ok = ((state == S_IDLE) || (state == S_DONE)) && START;

    // Values as they will be once this edge captures MEM_DATA; these feed EA only, never MEM_ADDR.
    assign b_v  = (state == S_OPL)  ? MEM_DATA : b_q;
    assign h_v  = (state == S_OPH)  ? MEM_DATA : h_q;
    assign ph_v = (state == S_PTRH) ? MEM_DATA : ph_q;

    assign idx       = (mode_q == M_ABX) ? x_q  : y_q;
    assign base_lo   = (mode_q == M_IZY) ? pl_q : b_q;
    assign base_hi_q = (mode_q == M_IZY) ? ph_q : h_q;
    assign base_hi_v = (mode_q == M_IZY) ? ph_v : h_v;
    assign lo_sum    = {1'b0, base_lo} + {1'b0, idx};
    assign carry     = lo_sum[DATA_W];
    assign fix_need  = carry || wr_q || FIX_ALWAYS;
    assign hi_inc    = base_hi_v + {{(DATA_W-1){1'b0}}, carry};
    assign is_abs    = (mode_q == M_ABS) || (mode_q == M_ABX) || (mode_q == M_ABY);

    // State register
    always_ff @(posedge CLK or negedge R) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!R) state <= S_IDLE;
        else    state <= state_n;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path leaves state_n unassigned, which would infer a latch.
        state_n = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) state_n = (mode_t'(MODE) == M_IMM) ? S_DONE : S_OPL;
                else       state_n = S_IDLE;
            end
            S_OPL: if (MEM_ACK) begin
                case (mode_q)
                    M_ZP, M_ZPX, M_IMM: state_n = S_DONE;
                    M_IZX, M_IZY:       state_n = S_PTRL;
                    default:            state_n = S_OPH;
                endcase
            end
            S_OPH:  if (MEM_ACK) state_n = (mode_q == M_ABS) ? S_DONE : (fix_need ? S_FIX : S_DONE);
            S_PTRL: if (MEM_ACK) state_n = S_PTRH;
            S_PTRH: if (MEM_ACK) state_n = (mode_q == M_IZX) ? S_DONE : (fix_need ? S_FIX : S_DONE);
            S_FIX:  if (MEM_ACK) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        ea_next = '0;
        case (mode_q)
            M_ZP:    ea_next = {{DATA_W{1'b0}}, b_v};
            M_ZPX:   ea_next = zp_addr(b_v, x_q, 1'b0);
            M_IZX:   ea_next = {ph_v, pl_q};
            M_ABS:   ea_next = {h_v, b_q};
            M_IMM:   ea_next = pc_q;
            default: ea_next = {hi_inc, lo_sum[DATA_W-1:0]};
        endcase
    end

    // Latched request, captured bytes and result registers
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            mode_q  <= M_IZX;
            wr_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pc_q    <= '0;
            b_q     <= '0;
            h_q     <= '0;
            pl_q    <= '0;
            ph_q    <= '0;
            ea_q    <= '0;
            oplen_q <= '0;
            extra_q <= 1'b0;
        end else begin
            if (start_ok) begin
                mode_q <= mode_t'(MODE);
                wr_q   <= WR_OP;
                x_q    <= IDX_X;
                y_q    <= IDX_Y;
                pc_q   <= PC_IN;
                if (mode_t'(MODE) == M_IMM) begin
                    ea_q    <= PC_IN;
                    oplen_q <= 2'd1;
                    extra_q <= 1'b0;
                end
            end
            if (ack_ok) begin
                case (state)
                    S_OPL:   b_q  <= MEM_DATA;
                    S_OPH:   h_q  <= MEM_DATA;
                    S_PTRL:  pl_q <= MEM_DATA;
                    S_PTRH:  ph_q <= MEM_DATA;
                    default: ;
                endcase
                if (state_n == S_DONE) begin
                    ea_q    <= ea_next;
                    oplen_q <= is_abs ? 2'd2 : 2'd1;
                    extra_q <= (state == S_FIX);
                end
            end
        end
    end

    // Outputs from registered state and latched/captured values only
    always_comb begin
        MEM_REQ  = access;
        BUSY     = access;
        DONE     = (state == S_DONE);
        MEM_ADDR = '0;
        case (state)
            S_OPL:   MEM_ADDR = pc_q;
            S_OPH:   MEM_ADDR = pc_q + {{(AW-1){1'b0}}, 1'b1};
            S_PTRL:  MEM_ADDR = zp_addr(b_q, (mode_q == M_IZX) ? x_q : '0, 1'b0);
            S_PTRH:  MEM_ADDR = zp_addr(b_q, (mode_q == M_IZX) ? x_q : '0, 1'b1);
            S_FIX:   MEM_ADDR = {base_hi_q, lo_sum[DATA_W-1:0]};
            default: MEM_ADDR = '0;
        endcase
    end

    assign EA    = ea_q;
    assign OPLEN = oplen_q;
    assign EXTRA = extra_q;

endmodule
